// File: rtl/overture_pkg.sv
// rtl/overture_pkg.sv - shared types and constants for the Overture execution core
// Purpose: instruction class, ALU op and condition encodings, register index
//          constants, FSM state type and the branch condition evaluator.
// Ports:   none (package).
package overture_pkg;

  // Instruction class taken from rom_data[7:6].
  typedef enum logic [1:0] {
    CLS_IMM  = 2'b00,
    CLS_CALC = 2'b01,
    CLS_COPY = 2'b10,
    CLS_COND = 2'b11
  } instr_class_e;

  // ALU op codes from rom_data[2:0] of a compute instruction; 6 and 7 are NOPs.
  localparam logic [2:0] ALU_OR   = 3'd0;
  localparam logic [2:0] ALU_NAND = 3'd1;
  localparam logic [2:0] ALU_NOR  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_ADD  = 3'd4;
  localparam logic [2:0] ALU_SUB  = 3'd5;

  // Condition codes from rom_data[2:0] of a condition instruction.
  localparam logic [2:0] COND_NEVER  = 3'd0;
  localparam logic [2:0] COND_EQZ    = 3'd1;
  localparam logic [2:0] COND_LTZ    = 3'd2;
  localparam logic [2:0] COND_LEZ    = 3'd3;
  localparam logic [2:0] COND_ALWAYS = 3'd4;
  localparam logic [2:0] COND_NEZ    = 3'd5;
  localparam logic [2:0] COND_GEZ    = 3'd6;
  localparam logic [2:0] COND_GTZ    = 3'd7;

  // Register indices used by copy source/destination fields.
  localparam logic [2:0] REG_R0   = 3'd0;
  localparam logic [2:0] REG_R1   = 3'd1;
  localparam logic [2:0] REG_R2   = 3'd2;
  localparam logic [2:0] REG_R3   = 3'd3;
  localparam logic [2:0] REG_R4   = 3'd4;
  localparam logic [2:0] REG_R5   = 3'd5;
  localparam logic [2:0] REG_IO   = 3'd6;
  localparam logic [2:0] REG_NULL = 3'd7;

  localparam int NUM_REGS = 6;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_OUT_WAIT = 1'b1
  } state_e;

  // Evaluates a branch condition against r3 interpreted as two's complement.
  function automatic logic cond_true(input logic [2:0] code, input logic [7:0] val);
    logic zero;
    logic neg;
    logic res;
    zero = (val == 8'd0);
    neg  = val[7];
    res  = 1'b0;
    case (code)
      COND_NEVER:  res = 1'b0;
      COND_EQZ:    res = zero;
      COND_LTZ:    res = neg;
      COND_LEZ:    res = neg | zero;
      COND_ALWAYS: res = 1'b1;
      COND_NEZ:    res = ~zero;
      COND_GEZ:    res = ~neg;
      COND_GTZ:    res = ~neg & ~zero;
      default:     res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/overture_alu.sv
// rtl/overture_alu.sv - combinational 8-bit ALU for compute instructions
// Purpose: y = f(a, b) for the six compute operations; NOP codes yield 0 and
//          are never written back by the core.
// Ports:   op [2:0] operation select, a [7:0] (r1), b [7:0] (r2), y [7:0] result.
module overture_alu
  import overture_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  always_comb begin
    y = 8'd0;
    case (op)
      ALU_OR:   y = a | b;
      ALU_NAND: y = ~(a & b);
      ALU_NOR:  y = ~(a | b);
      ALU_AND:  y = a & b;
      ALU_ADD:  y = a + b;   // wraps modulo 256, no carry out
      ALU_SUB:  y = a - b;   // wraps modulo 256, no borrow out
      default:  y = 8'd0;
    endcase
  end

endmodule

// File: rtl/overture_core.sv
// rtl/overture_core.sv - Overture program-sequencing execution core
// Purpose: fetches from an external combinational ROM at the PC, decodes the
//          immediate/compute/copy/condition classes and executes them on r0..r5,
//          with valid/ready input and output channels that stall the PC.
// Ports:   clk, rst_n (async active-low);
//          rom_addr [7:0] out = PC, rom_data [7:0] in = instruction byte;
//          in_data/in_valid in, in_ready out (combinational);
//          out_data/out_valid out (registered), out_ready in;
//          retired out: one-cycle registered pulse per completed instruction.
module overture_core
  import overture_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       retired
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] regs_q [NUM_REGS];
  logic [7:0] regs_d [NUM_REGS];
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       retired_q, retired_d;

  instr_class_e cls;
  logic [2:0]   src;
  logic [2:0]   dst;
  logic [7:0]   src_val;
  logic [7:0]   alu_y;
  logic [7:0]   pc_inc;

  assign cls    = instr_class_e'(rom_data[7:6]);
  assign src    = rom_data[5:3];
  assign dst    = rom_data[2:0];
  assign pc_inc = pc_q + 8'd1;   // 0xFF rolls over to 0x00

  overture_alu u_alu (
    .op (rom_data[2:0]),
    .a  (regs_q[1]),
    .b  (regs_q[2]),
    .y  (alu_y)
  );

  // Copy source mux: registers, the input channel, or the constant zero.
  always_comb begin
    src_val = 8'd0;
    if (src == REG_IO) begin
      src_val = in_data;
    end else if (src != REG_NULL) begin
      src_val = regs_q[src];
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    regs_d      = regs_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    retired_d   = 1'b0;
    in_ready    = 1'b0;

    case (state_q)
      ST_RUN: begin
        case (cls)
          CLS_IMM: begin
            regs_d[0] = {2'b00, rom_data[5:0]};
            pc_d      = pc_inc;
            retired_d = 1'b1;
          end
          CLS_CALC: begin
            // NOP codes still retire, they just leave r3 alone.
            if (rom_data[2:0] <= ALU_SUB) begin
              regs_d[3] = alu_y;
            end
            pc_d      = pc_inc;
            retired_d = 1'b1;
          end
          CLS_COPY: begin
            in_ready = (src == REG_IO);
            // An input-sourced copy does nothing until in_valid arrives.
            if ((src != REG_IO) || in_valid) begin
              if (dst == REG_IO) begin
                // Output beat: PC and retire wait for the accept in OUT_WAIT.
                out_data_d  = src_val;
                out_valid_d = 1'b1;
                state_d     = ST_OUT_WAIT;
              end else begin
                if (dst != REG_NULL) begin
                  regs_d[dst] = src_val;
                end
                pc_d      = pc_inc;
                retired_d = 1'b1;
              end
            end
          end
          CLS_COND: begin
            pc_d      = cond_true(dst, regs_q[3]) ? regs_q[0] : pc_inc;
            retired_d = 1'b1;
          end
          default: begin
            state_d = ST_RUN;
          end
        endcase
      end
      ST_OUT_WAIT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          pc_d        = pc_inc;
          retired_d   = 1'b1;
          state_d     = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pc_q        <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= 8'd0;
      end
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      retired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      regs_q      <= regs_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      retired_q   <= retired_d;
    end
  end

  assign rom_addr  = pc_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign retired   = retired_q;

endmodule
